// File: rtl/pkt_pkg.sv
// Shared types and widths for the packet capture buffer.
package pkt_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DRAIN,
        R_WAIT
    } rd_state_t;

    localparam int TS_W       = 32;
    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/pkt_buf_mem.sv
// Simple dual-port storage for pkt_buf: one write port, one read port with a registered output.
module pkt_buf_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            o_rdata <= '0;
        else if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/pkt_buf.sv
// Packet capture buffer: stores only complete packets and drains one per rd_ctrl/wr_ctrl handshake.
// Optional feature macro: PKT_BUF_TIMESTAMP_EN adds a per-packet sop timestamp on out_ts.
module pkt_buf
    import pkt_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 64,
    parameter int MAX_PKTS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  new_request,
    input  logic                  rd_ctrl,
    input  logic                  wr_ctrl,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_eop,
    output logic                  busy,
`ifdef PKT_BUF_TIMESTAMP_EN
    output logic [TS_W-1:0]       out_ts,
`endif
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int CNT_W = $clog2(MAX_PKTS) + 1;

    rd_state_t          r_state;
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr, r_wr_start;
    logic [CNT_W-1:0]   r_pkt_cnt;
    logic               r_in_pkt, r_out_valid, r_wr_latched;

    logic [PTR_W-1:0]   w_base, w_used, w_wr_ptr_n, w_start_n;
    logic               w_in_pkt_n, w_we, w_commit, w_sop_acc;
    logic [1:0]         w_drop_inc;
    logic [DROP_CNT_W:0] w_drop_sum;
    logic [DATA_W:0]    w_rdata;
    logic               w_rd_eop, w_rd_en, w_release, w_drain_start;

    assign w_rd_eop      = r_out_valid & w_rdata[DATA_W];
    assign w_drain_start = (r_state == R_IDLE) && rd_ctrl && (r_pkt_cnt != '0);
    assign w_release     = (r_state == R_DRAIN) && w_rd_eop;
    assign w_rd_en       = w_drain_start || ((r_state == R_DRAIN) && !w_rd_eop);

    assign new_request = (r_state == R_IDLE) && (r_pkt_cnt != '0);
    assign busy        = (r_state != R_IDLE);
    assign out_valid   = r_out_valid;
    assign out_data    = w_rdata[DATA_W-1:0];
    assign out_eop     = w_rd_eop;

    // A new sop on an open packet rewinds to its start; the full check is made against the rewound base.
    always_comb begin
        w_base     = r_wr_ptr;
        w_start_n  = r_wr_start;
        w_in_pkt_n = r_in_pkt;
        w_wr_ptr_n = r_wr_ptr;
        w_we       = 1'b0;
        w_commit   = 1'b0;
        w_sop_acc  = 1'b0;
        w_drop_inc = 2'd0;
        w_used     = '0;
        if (in_valid) begin
            if (in_sop) begin
                w_sop_acc = 1'b1;
                if (r_in_pkt) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                    w_base     = r_wr_start;
                end
                w_start_n  = w_base;
                w_in_pkt_n = 1'b1;
            end
            if (w_in_pkt_n) begin
                w_used = w_base - r_rd_ptr;
                if (w_used == PTR_W'(DEPTH)) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                    w_wr_ptr_n = w_start_n;
                    w_in_pkt_n = 1'b0;
                end else begin
                    w_we       = 1'b1;
                    w_wr_ptr_n = w_base + PTR_W'(1);
                    if (in_eop) begin
                        w_in_pkt_n = 1'b0;
                        if ((r_pkt_cnt < CNT_W'(MAX_PKTS)) || w_release) begin
                            w_commit = 1'b1;
                        end else begin
                            w_drop_inc = w_drop_inc + 2'd1;
                            w_wr_ptr_n = w_start_n;
                        end
                    end
                end
            end
        end
    end

    assign w_drop_sum = {1'b0, drop_cnt} + (DROP_CNT_W+1)'(w_drop_inc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_wr_start <= '0;
            r_in_pkt   <= 1'b0;
            r_pkt_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_n;
            r_wr_start <= w_start_n;
            r_in_pkt   <= w_in_pkt_n;
            drop_cnt   <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
            if (w_commit && !w_release)
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            else if (w_release && !w_commit)
                r_pkt_cnt <= r_pkt_cnt - CNT_W'(1);
        end
    end

    // The read register already shows the current byte, so the eop decision uses the displayed entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= R_IDLE;
            r_rd_ptr     <= '0;
            r_out_valid  <= 1'b0;
            r_wr_latched <= 1'b0;
        end else begin
            r_out_valid <= w_rd_en;
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case (r_state)
                R_IDLE: begin
                    r_wr_latched <= 1'b0;
                    if (w_drain_start)
                        r_state <= R_DRAIN;
                end
                R_DRAIN: begin
                    if (wr_ctrl)
                        r_wr_latched <= 1'b1;
                    if (w_rd_eop) begin
                        r_state      <= (r_wr_latched || wr_ctrl) ? R_IDLE : R_WAIT;
                        r_wr_latched <= 1'b0;
                    end
                end
                R_WAIT: begin
                    if (wr_ctrl)
                        r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    pkt_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (w_base[AW-1:0]),
        .i_wdata ({in_eop, in_data}),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

`ifdef PKT_BUF_TIMESTAMP_EN
    localparam int TSI_W = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;

    logic [TS_W-1:0]  r_cycle, r_ts_cap;
    logic [TS_W-1:0]  r_ts_mem [MAX_PKTS];
    logic [TSI_W-1:0] r_ts_wr, r_ts_rd;

    always_ff @(posedge clk) begin
        if (w_commit)
            r_ts_mem[r_ts_wr] <= w_sop_acc ? r_cycle : r_ts_cap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle  <= '0;
            r_ts_cap <= '0;
            r_ts_wr  <= '0;
            r_ts_rd  <= '0;
            out_ts   <= '0;
        end else begin
            r_cycle <= r_cycle + TS_W'(1);
            if (w_sop_acc)
                r_ts_cap <= r_cycle;
            if (w_commit)
                r_ts_wr <= (r_ts_wr == TSI_W'(MAX_PKTS-1)) ? '0 : r_ts_wr + TSI_W'(1);
            if (w_drain_start) begin
                out_ts  <= r_ts_mem[r_ts_rd];
                r_ts_rd <= (r_ts_rd == TSI_W'(MAX_PKTS-1)) ? '0 : r_ts_rd + TSI_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_buf.sv
// Directed scoreboard bench for pkt_buf: stored bytes are queued when driven and checked when drained.
module tb_pkt_buf;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 64;
    localparam int MAX_PKTS = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_sop, in_eop, rd_ctrl, wr_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              new_request, out_valid, out_eop, busy;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       drop_cnt;
`ifdef PKT_BUF_TIMESTAMP_EN
    logic [31:0]       out_ts;
`endif

    logic [DATA_W:0]   expQ [$];
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    pkt_buf #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .MAX_PKTS (MAX_PKTS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .new_request (new_request),
        .rd_ctrl     (rd_ctrl),
        .wr_ctrl     (wr_ctrl),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_eop     (out_eop),
        .busy        (busy),
`ifdef PKT_BUF_TIMESTAMP_EN
        .out_ts      (out_ts),
`endif
        .drop_cnt    (drop_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = '0;
        rd_ctrl  = 1'b0;
        wr_ctrl  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic sop, input logic eop);
        in_valid = 1'b1;
        in_data  = data;
        in_sop   = sop;
        in_eop   = eop;
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic sendPkt(input int len, input logic [7:0] base, input bit store);
        for (int i = 0; i < len; i++) begin
            logic [7:0] d;
            d = base + 8'(i);
            if (store)
                expQ.push_back({(i == len - 1) ? 1'b1 : 1'b0, d});
            applyStimulus(d, i == 0, i == len - 1);
        end
    endtask

    // Byte i of the drained packet must appear exactly i+1 cycles after rd_ctrl is sampled.
    task automatic drainPkt(input int len, input bit earlyWr, input bit inject, input logic [7:0] injData);
        rd_ctrl = 1'b1;
        tick();
        rd_ctrl = 1'b0;
        checkOutput("busy_after_rd", busy, 1);
        checkOutput("newreq_after_rd", new_request, 0);
        for (int i = 0; i < len; i++) begin
            checkOutput("out_valid_drain", out_valid, 1);
            checks++;
            assert (expQ.size() > 0) else begin
                errors++;
                $error("[TB] FAIL sb_underflow observed=empty expected=entry");
            end
            if (expQ.size() > 0)
                checkOutput("out_byte", {out_eop, out_data}, expQ.pop_front());
            if (earlyWr && i == 0)
                wr_ctrl = 1'b1;
            if (inject && i == len - 1) begin
                in_valid = 1'b1;
                in_sop   = 1'b1;
                in_eop   = 1'b1;
                in_data  = injData;
                expQ.push_back({1'b1, injData});
            end
            tick();
            clearInputs();
        end
        checkOutput("out_valid_after", out_valid, 0);
        if (earlyWr) begin
            checkOutput("busy_early_wr", busy, 0);
        end else begin
            checkOutput("busy_wait", busy, 1);
            tick();
            checkOutput("busy_wait_hold", busy, 1);
            checkOutput("newreq_wait", new_request, 0);
            wr_ctrl = 1'b1;
            tick();
            wr_ctrl = 1'b0;
            checkOutput("busy_after_wr", busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearInputs();
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("rst_new_request", new_request, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_eop", out_eop, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;
        tick();

        $display("[TB] rd_ctrl with nothing stored");
        rd_ctrl = 1'b1;
        tick();
        rd_ctrl = 1'b0;
        checkOutput("rd_ignored_busy", busy, 0);
        applyStimulus(8'h99, 1'b0, 1'b1);
        checkOutput("no_sop_ignored", new_request, 0);

        $display("[TB] single 4-byte packet");
        expQ.push_back({1'b0, 8'h11});
        expQ.push_back({1'b0, 8'h12});
        expQ.push_back({1'b0, 8'h13});
        expQ.push_back({1'b1, 8'h14});
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h12, 1'b0, 1'b0);
        applyStimulus(8'h13, 1'b0, 1'b0);
        checkOutput("newreq_before_eop", new_request, 0);
        applyStimulus(8'h14, 1'b0, 1'b1);
        checkOutput("newreq_after_eop", new_request, 1);
        drainPkt(4, 1'b0, 1'b0, 8'h00);
        checkOutput("newreq_empty", new_request, 0);

        $display("[TB] three 1-byte packets");
        sendPkt(1, 8'h21, 1'b1);
        sendPkt(1, 8'h22, 1'b1);
        sendPkt(1, 8'h23, 1'b1);
        drainPkt(1, 1'b0, 1'b0, 8'h00);
        checkOutput("newreq_two_left", new_request, 1);
        drainPkt(1, 1'b0, 1'b0, 8'h00);
        checkOutput("newreq_one_left", new_request, 1);
        drainPkt(1, 1'b0, 1'b0, 8'h00);
        checkOutput("newreq_none_left", new_request, 0);

        $display("[TB] oversize packet");
        sendPkt(70, 8'h40, 1'b0);
        checkOutput("drop_oversize", drop_cnt, 1);
        checkOutput("newreq_oversize", new_request, 0);
        sendPkt(5, 8'h50, 1'b1);
        checkOutput("newreq_after_5", new_request, 1);
        drainPkt(5, 1'b0, 1'b0, 8'h00);

        $display("[TB] sop inside open packet");
        applyStimulus(8'hA0, 1'b1, 1'b0);
        applyStimulus(8'hA1, 1'b0, 1'b0);
        sendPkt(3, 8'hB0, 1'b1);
        checkOutput("drop_restart", drop_cnt, 2);
        drainPkt(3, 1'b1, 1'b0, 8'h00);
        checkOutput("newreq_restart", new_request, 0);

        $display("[TB] packet count limit");
        for (int p = 0; p < MAX_PKTS; p++)
            sendPkt(2, 8'hC0 + 8'(2 * p), 1'b1);
        sendPkt(2, 8'hF0, 1'b0);
        checkOutput("drop_pkt_limit", drop_cnt, 3);
        drainPkt(2, 1'b0, 1'b1, 8'hE0);
        checkOutput("drop_commit_release", drop_cnt, 3);
        for (int p = 1; p < MAX_PKTS; p++)
            drainPkt(2, 1'b0, 1'b0, 8'h00);
        drainPkt(1, 1'b0, 1'b0, 8'h00);
        checkOutput("newreq_limit_done", new_request, 0);
        checkOutput("sb_empty", expQ.size(), 0);

        $display("[TB] reset mid-drain");
        sendPkt(4, 8'h31, 1'b1);
        rd_ctrl = 1'b1;
        tick();
        rd_ctrl = 1'b0;
        tick();
        checkOutput("mid_drain_byte2", out_data, 8'h32);
        reset = 1'b1;
        tick();
        checkOutput("rst_mid_out_valid", out_valid, 0);
        checkOutput("rst_mid_out_data", out_data, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_new_request", new_request, 0);
        checkOutput("rst_mid_drop_cnt", drop_cnt, 0);
        reset = 1'b0;
        expQ.delete();
        tick();
        checkOutput("post_rst_new_request", new_request, 0);
        checkOutput("post_rst_out_valid", out_valid, 0);
        sendPkt(2, 8'h77, 1'b1);
        checkOutput("post_rst_stored", new_request, 1);
        drainPkt(2, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_buf.md
# pkt_buf

Packet capture buffer feeding `pkt_ctrl`: it is the responder end of the `new_request` / `rd_ctrl` / `wr_ctrl` handshake. It accepts a tapped byte stream with no backpressure and stores complete packets only. It raises `new_request` while at least one committed packet is held. On `rd_ctrl` it drains one packet, byte per cycle, and it returns to idle on `wr_ctrl`.

## Interface
Parameters:
- `DATA_W`, 8: byte/word width of the captured stream
- `DEPTH`, 64: storage entries (power of 2, ≥4)
- `MAX_PKTS`, 8: max committed packets held (power of 2)

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: asynchronous, active-high; clears all state
- `in_valid` in 1: capture byte present this cycle
- `in_data` in DATA_W: capture byte
- `in_sop` in 1: first byte of packet
- `in_eop` in 1: last byte of packet (may coincide with `in_sop`)
- `new_request` out 1: committed packet available and reader idle
- `rd_ctrl` in 1: start drain of oldest packet
- `wr_ctrl` in 1: packet consumed; release reader
- `out_valid` out 1: `out_data` valid
- `out_data` out DATA_W: drained byte
- `out_eop` out 1: last byte of drained packet
- `busy` out 1: reader not idle
- `drop_cnt` out 16: saturating count of dropped packets

## Operation
- Storage entries are DATA_W+1 bits wide: byte plus eop flag. Pointers are log2(DEPTH)+1 bits. Full means `wr_ptr - rd_ptr == DEPTH`.
- Writer: bytes before the first `in_sop` are ignored (not in packet).
- `in_sop` records `wr_start = wr_ptr` and enters the in-packet state. The byte is written when `in_valid`.
- If a byte arrives while full, the packet is dropped:
  - `wr_ptr` rewinds to `wr_start`.
  - `drop_cnt`++.
  - Remaining bytes are discarded until the next `in_sop`.
- `in_sop` while in-packet: the partial packet is dropped (rewind, `drop_cnt`++) and a new packet starts with this byte.
- `in_eop` byte written: commit.
  - If `pkt_cnt < MAX_PKTS`, or a release happens in the same cycle, `pkt_cnt`++.
  - Otherwise the packet is dropped (rewind, `drop_cnt`++).
- Reader FSM, states R_IDLE, R_DRAIN, R_WAIT:
  - R_IDLE: `new_request = (pkt_cnt != 0)`. If `rd_ctrl && pkt_cnt != 0`, go to R_DRAIN. `rd_ctrl` with `pkt_cnt == 0` is ignored.
  - R_DRAIN: read one entry per cycle and `rd_ptr`++. On the eop entry: `pkt_cnt`-- (release) and go to R_WAIT, or to R_IDLE if `wr_ctrl` was latched during the drain.
  - R_WAIT: on `wr_ctrl`, go to R_IDLE.
- `rd_ctrl` outside R_IDLE is ignored. `wr_ctrl` in R_IDLE is ignored.
- Simultaneous commit and release leaves `pkt_cnt` unchanged.
- The reader only consumes committed bytes. A speculative write never overtakes `rd_ptr`, enforced by the full check.
- `drop_cnt` saturates at 0xFFFF.

## Timing
- All outputs reset to 0. FSM resets to R_IDLE. Pointers, `pkt_cnt` and `wr_start` reset to 0, and the in-packet flag is cleared. Reset mid-drain or mid-packet discards everything; no output pulse follows.
- `in_eop` accepted in cycle N: `new_request` is high in cycle N+1, provided the reader is idle.
- `rd_ctrl` sampled in cycle M: `new_request` and `busy` change in M+1. The first `out_valid` byte appears in M+1 (registered read). A packet of L bytes occupies cycles M+1..M+L, contiguous, with `out_eop` in M+L.
- `busy` is high from M+1 until the cycle after `wr_ctrl` is accepted.
- Back-to-back: the earliest next `rd_ctrl` is accepted in the cycle after return to R_IDLE.

## Configuration
- `PKT_BUF_TIMESTAMP_EN` defined:
  - A 32-bit free-running cycle counter starts at 0 after reset.
  - Its value is captured at accepted `in_sop` and written at commit into a MAX_PKTS-entry timestamp array.
  - Extra output `out_ts` (32) holds the drained packet's timestamp, stable from M+1 through R_WAIT. It is 0 in reset.
- Undefined: no counter, no array, no `out_ts` port; behaviour otherwise identical.

## Structure
- Package `pkt_pkg`: enum `rd_state_t` {R_IDLE, R_DRAIN, R_WAIT}, `TS_W = 32`, `DROP_CNT_W = 16`.
- Sub-module `pkt_buf_mem`: simple dual-port RAM, DEPTH x (DATA_W+1), one write port, one read port with registered output.

## Test plan
- Single 4-byte packet 0x11..0x14 with sop/eop; `rd_ctrl` one cycle -> `new_request` high 1 cycle after eop; `out_data` 0x11..0x14 in 4 consecutive cycles; `out_eop` on 0x14; FSM in R_WAIT until `wr_ctrl`.
- Three 1-byte packets (sop=eop) back-to-back, then three rd/wr cycles -> bytes returned in order; `new_request` falls after the third release.
- DEPTH=64, 70-byte packet -> dropped, `drop_cnt`=1, `new_request` stays 0. A following 5-byte packet is stored and drained intact.
- `in_sop` at byte 3 of an unfinished packet -> `drop_cnt`+1; only the new packet is drained.
- MAX_PKTS+1 short packets with no reads -> last packet dropped, `pkt_cnt`=MAX_PKTS. Commit during a drain-release cycle -> accepted.
- `reset` asserted mid-drain at byte 2 -> all outputs 0 next cycle; `new_request` 0. With `PKT_BUF_TIMESTAMP_EN`, `out_ts` equals the sop cycle count.
